// File: rtl/tt_um_richard28277.sv
// Registered 4-bit ALU tile: A=ui_in[7:4], B=ui_in[3:0], opcode=uio_in[3:0].
// Define ALU_MULDIV_EN to build the multiplier/divider (opcodes 2-4); otherwise they report ERR.
module tt_um_richard28277 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] w_a, w_b, w_op;
  logic [1:0] w_sh;
  logic [4:0] w_sum, w_diff;
  logic [7:0] w_shl, w_shr, w_rol, w_ror;
  logic [7:0] w_r;
  logic       w_carry, w_ovf, w_err, w_zero;
  logic [7:0] r_res;
  logic [3:0] r_flags;
  logic       w_unused;

  assign w_a      = ui_in[7:4];
  assign w_b      = ui_in[3:0];
  assign w_op     = uio_in[3:0];
  assign w_sh     = w_b[1:0];
  assign w_unused = &{1'b0, uio_in[7:4]};

  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  // Wide shifts keep the last bit shifted out in a fixed position for CARRY.
  assign w_shl  = {4'b0, w_a} << w_sh;
  assign w_shr  = {w_a, 4'b0} >> w_sh;
  assign w_rol  = {w_a, w_a} << w_sh;
  assign w_ror  = {w_a, w_a} >> w_sh;

  always_comb begin
    w_r     = 8'h00;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (w_op)
      4'd0: begin
        w_r     = {3'b0, w_sum};
        w_carry = w_sum[4];
        w_ovf   = (w_a[3] == w_b[3]) && (w_sum[3] != w_a[3]);
      end
      4'd1: begin
        w_r     = {4'b0, w_diff[3:0]};
        w_carry = w_diff[4];
        w_ovf   = (w_a[3] != w_b[3]) && (w_diff[3] != w_a[3]);
      end
`ifdef ALU_MULDIV_EN
      4'd2: w_r = {4'b0, w_a} * {4'b0, w_b};
      4'd3: begin
        if (w_b == 4'd0) begin
          w_r   = 8'hFF;
          w_err = 1'b1;
        end else begin
          w_r = {4'b0, w_a / w_b};
        end
      end
      4'd4: begin
        if (w_b == 4'd0) begin
          w_r   = 8'hFF;
          w_err = 1'b1;
        end else begin
          w_r = {4'b0, w_a % w_b};
        end
      end
`else
      4'd2, 4'd3, 4'd4: begin
        w_r   = 8'hFF;
        w_err = 1'b1;
      end
`endif
      4'd5:  w_r = {4'b0, w_a & w_b};
      4'd6:  w_r = {4'b0, w_a | w_b};
      4'd7:  w_r = {4'b0, w_a ^ w_b};
      4'd8:  w_r = {4'b0, ~w_a};
      4'd9:  w_r = {7'b0, w_a < w_b};
      4'd10: w_r = {7'b0, w_a == w_b};
      4'd11: begin
        w_r     = {4'b0, w_shl[3:0]};
        w_carry = w_shl[4];
      end
      4'd12: begin
        w_r     = {4'b0, w_shr[7:4]};
        w_carry = w_shr[3];
      end
      4'd13: w_r = {4'b0, w_rol[7:4]};
      4'd14: w_r = {4'b0, w_ror[3:0]};
      default: w_r = {w_a, w_b};
    endcase
  end

  assign w_zero = (w_r == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= 8'h00;
      r_flags <= 4'h0;
    end else if (ena) begin
      r_res   <= w_r;
      r_flags <= {w_err, w_ovf, w_zero, w_carry};
    end
  end

  assign uo_out  = r_res;
  assign uio_out = {r_flags, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_richard28277.sv
// Directed plus randomized checks of the registered ALU against an arithmetic reference model.
module tb_tt_um_richard28277;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] exp_st;  // {ERR,OVF,ZERO,CARRY, R}

  tt_um_richard28277 dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model(input int a, input int b, input int op);
    int r, s, sa, sb;
    bit c, o, e, z;
    r = 0; c = 0; o = 0; e = 0;
    s  = b % 4;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    case (op)
      0: begin r = a + b; c = (r > 15); o = (sa + sb > 7) || (sa + sb < -8); end
      1: begin r = (a - b + 16) % 16; c = (a < b); o = (sa - sb > 7) || (sa - sb < -8); end
`ifdef ALU_MULDIV_EN
      2: r = a * b;
      3: if (b == 0) begin r = 255; e = 1; end else r = a / b;
      4: if (b == 0) begin r = 255; e = 1; end else r = a % b;
`else
      2, 3, 4: begin r = 255; e = 1; end
`endif
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = 15 - a;
      9: r = (a < b) ? 1 : 0;
      10: r = (a == b) ? 1 : 0;
      11: begin r = (a * (1 << s)) % 16; c = (s != 0) && (((a >> (4 - s)) & 1) == 1); end
      12: begin r = a >> s; c = (s != 0) && (((a >> (s - 1)) & 1) == 1); end
      13: r = ((a << s) | (a >> (4 - s))) & 15;
      14: r = ((a >> s) | (a << (4 - s))) & 15;
      default: r = a * 16 + b;
    endcase
    z = (r == 0);
    return {e, o, z, c, 8'(r)};
  endfunction

  task automatic chk(input string tag, input logic [11:0] want);
    logic [23:0] obs, exp;
    obs = {uio_oe, uio_out, uo_out};
    exp = {8'hF0, want[11:8], 4'h0, want[7:0]};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed oe/uio/uo=%h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after an edge, clock once, then check 1 ns after the edge.
  task automatic cyc(input string tag, input int a, input int b, input int op, input bit en);
    ui_in  = {4'(a), 4'(b)};
    uio_in = {4'($urandom), 4'(op)};
    ena    = en;
    @(posedge clk);
    #1;
    if (en) exp_st = model(a, b, op);
    chk(tag, exp_st);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    exp_st = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 12'h000);
    rst_n = 1'b1;

    cyc("add_3_4", 3, 4, 0, 1);
    chk("add_3_4_val", 12'h007);
    cyc("add_ovf", 9, 8, 0, 1);
    chk("add_ovf_val", 12'h511);
    cyc("sub_borrow", 2, 5, 1, 1);
    chk("sub_borrow_val", 12'h10D);
`ifdef ALU_MULDIV_EN
    cyc("mul_ff", 15, 15, 2, 1);
    chk("mul_ff_val", 12'h0E1);
    cyc("div", 13, 4, 3, 1);
    chk("div_val", 12'h003);
    cyc("mod", 13, 4, 4, 1);
    chk("mod_val", 12'h001);
    cyc("div0", 13, 0, 3, 1);
    chk("div0_val", 12'h8FF);
    cyc("mod0", 7, 0, 4, 1);
`else
    cyc("mul_off", 15, 15, 2, 1);
    chk("mul_off_val", 12'h8FF);
    cyc("div_off", 13, 4, 3, 1);
    cyc("mod_off", 13, 4, 4, 1);
`endif
    cyc("and_zero", 10, 5, 5, 1);
    chk("and_zero_val", 12'h200);
    cyc("or", 10, 5, 6, 1);
    cyc("pass", 10, 5, 15, 1);
    chk("pass_val", 12'h0A5);
    cyc("shl", 9, 1, 11, 1);
    chk("shl_val", 12'h102);
    cyc("rol", 9, 1, 13, 1);
    cyc("ror", 9, 1, 14, 1);
    chk("ror_val", 12'h00C);
    cyc("shr_c", 9, 3, 12, 1);
    cyc("shl0", 9, 4, 11, 1);
    cyc("lt", 3, 12, 9, 1);
    cyc("eq", 6, 6, 10, 1);
    cyc("not", 5, 0, 8, 1);

    for (int i = 0; i < 3; i++)
      cyc("hold", int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)), 0);

    for (int i = 0; i < 400; i++)
      cyc("rand", int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
          ($urandom_range(7) != 0));

    for (int op = 0; op < 16; op++)
      cyc("sweep_b0", int'($urandom_range(15)), 0, op, 1);

    cyc("pre_rst", 15, 15, 15, 1);
    rst_n = 1'b0;
    #1;
    exp_st = 12'h000;
    chk("async_rst", exp_st);
    @(posedge clk);
    #1;
    chk("rst_held", exp_st);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("post_rst", 3, 4, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
